ariane_irq_conditioner: RTL and testbench
=========================================

# ariane_irq_conditioner

Conditions the external interrupt lines from the FPGA fabric before they enter the peripherals subsystem's PLIC interrupt inputs (the 3-bit `irqs_in` bus). Each source is brought into the `aclk` domain through a synchronizer. It is then passed through as a level, or captured as a rising edge into a sticky latch. The latch is held for a minimum number of cycles so the PLIC gateway cannot miss a short pulse. Software or fabric clears edge latches explicitly, and a sticky overrun flag records edges lost while a latch was already set.

## Interface
Parameters:
- `NUM_IRQ`, 3: number of interrupt sources; equals the PLIC input width.
- `SYNC_STAGES`, 2: synchronizer depth; legal range ≥2.
- `HOLD_CYCLES`, 16: minimum high time of an edge-mode output, in `aclk` cycles; legal range ≥1.
- `EDGE_MASK`, `'0` (NUM_IRQ bits): bit i = 1 selects edge mode for source i; 0 selects level mode.

Ports:
- `aclk`, in, 1: the single clock.
- `areset`, in, 1: reset, synchronous and active-high.
- `irq_raw_i`, in, NUM_IRQ: asynchronous raw interrupt lines.
- `irq_en_i`, in, NUM_IRQ: per-source output enable (synchronous to `aclk`).
- `irq_clr_i`, in, NUM_IRQ: per-source clear for the edge latch and overrun flag (synchronous, sampled every edge).
- `irqs_out`, out, NUM_IRQ: conditioned interrupts, registered; connect to the peripherals' `irqs_in`.
- `irq_overrun_o`, out, NUM_IRQ: sticky overrun flags, registered.

## Operation
Per-source state:
- sync chain `SYNC_STAGES` flops, last stage `s`
- `prev` (s delayed one cycle)
- `latch`
- `cnt` (width clog2(HOLD_CYCLES)+1)
- `clr_pend`
- `ovr`
- `out_q`

Per-source logic:
- `rise = s & ~prev`.
- Level mode:
  - `out_q <= s & irq_en_i[i]`.
  - `latch`, `cnt`, `clr_pend` and `ovr` stay 0.
  - `irq_clr_i` is ignored.
- Edge mode, priority order each edge:
  1. `rise`: set `latch=1` and `cnt=HOLD_CYCLES-1`; `clr_pend` is cleared. If `latch` was already 1, set `ovr=1`. A rise in the same cycle as `irq_clr_i` wins and the clear is discarded.
  2. Else if `latch` and (`irq_clr_i` or `clr_pend`) and `cnt==0`: set `latch=0`, `ovr=0`, `clr_pend=0`.
  3. Else if `latch` and `irq_clr_i` and `cnt!=0`: set `clr_pend=1` (the clear is deferred).
  4. Independently, if `cnt!=0` and there is no rise, `cnt` decrements by 1.
- `out_q <= latch_next & irq_en_i[i]`, where `latch_next` is the value `latch` takes at this edge.
- `irq_en_i` low masks only the output. Latch, counter and overrun keep running, so a masked pending edge appears when the source is re-enabled.
- A clear on an idle source (`latch==0`) has no effect and does not set `clr_pend`.
- `irqs_out = out_q`; `irq_overrun_o = ovr`.

## Timing
- Reset:
  - At the edge where `areset` is sampled high, all flops (sync chain, `prev`, `latch`, `cnt`, `clr_pend`, `ovr`, `out_q`) go to 0.
  - `irqs_out` and `irq_overrun_o` therefore read 0 after that edge.
  - Reset mid-operation discards pending latches and deferred clears.
  - An edge-mode source still high when reset releases is re-detected as a rise once the sync chain refills. This is intended.
- Latency, for `irq_raw_i` first sampled high at edge k:
  - `s` is high after edge k+SYNC_STAGES-1.
  - `irqs_out` is high after edge k+SYNC_STAGES, in both modes with the enable set.
  - Level-mode deassertion has the same latency.
- Minimum pulse: in edge mode, a raw pulse sampled high at ≥1 edge (with stable synchronization) yields an `irqs_out` high for ≥HOLD_CYCLES cycles.
- Clear timing:
  - An undeferred clear at edge c drops `irqs_out` after edge c.
  - A deferred clear takes effect at the first edge where `cnt==0`, i.e. HOLD_CYCLES edges after the latching edge.
- Enable: a change on `irq_en_i` is visible on `irqs_out` after the next edge.

## Test plan
- Level mode, `EDGE_MASK=0`, `irq_raw_i[0]` high at edge 10, low at edge 30 → `irqs_out[0]` rises after edge 12 and falls after edge 32. `irq_clr_i` pulses have no effect.
- Edge mode, 1-cycle raw pulse at edge 10, `HOLD_CYCLES=16`, `irq_clr_i` pulse at edge 14 → latch after edge 12. The clear is deferred, so `irqs_out` stays high until after edge 28 (16 cycles high), then goes low. `irq_overrun_o=0`.
- Edge mode, second raw pulse at edge 40 while still latched from edge 20 → `irq_overrun_o` is set after edge 42 and `cnt` reloads. A clear at edge 70 drops both `irqs_out` and `irq_overrun_o` after edge 70.
- Simultaneous rise and `irq_clr_i` at the same edge → latch stays 1, `cnt=HOLD_CYCLES-1`, and the clear is discarded (not deferred).
- `irq_en_i[1]=0` while an edge latches → `irqs_out[1]` stays 0. Raising the enable at edge 50 → `irqs_out[1]` goes high after edge 50.
- `areset` asserted for 1 cycle while all three sources are latched and overrun → all outputs are 0 after that edge. A raw input held high then re-latches `SYNC_STAGES` edges after reset releases.

Source files
------------

// File: rtl/ariane_irq_conditioner.sv
// Conditions raw fabric interrupt lines for the PLIC: synchronise each source, then pass it
// through as a level or catch rising edges in a held, explicitly-cleared sticky latch.
module ariane_irq_conditioner #(
    parameter int unsigned          NUM_IRQ     = 3,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          HOLD_CYCLES = 16,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK   = '0
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_IRQ-1:0] irq_raw_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [NUM_IRQ-1:0] irq_clr_i,
    output logic [NUM_IRQ-1:0] irqs_out,
    output logic [NUM_IRQ-1:0] irq_overrun_o
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        localparam logic EDGE = EDGE_MASK[i];

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   latch_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   clr_pend_q;
        logic                   ovr_q;
        logic                   out_q;

        logic                   s;
        logic                   rise;
        logic                   latch_d;
        logic [CNT_W-1:0]       cnt_d;
        logic                   clr_pend_d;
        logic                   ovr_d;
        logic                   out_d;

        assign s    = sync_q[SYNC_STAGES-1];
        // Level-mode sources never see a rise, so their latch state stays at reset values.
        assign rise = EDGE & s & ~prev_q;

        // Next-state: a rise beats any clear; clears during the hold window are deferred.
        always_comb begin
            latch_d    = latch_q;
            cnt_d      = cnt_q;
            clr_pend_d = clr_pend_q;
            ovr_d      = ovr_q;
            if (rise) begin
                latch_d    = 1'b1;
                cnt_d      = CNT_W'(HOLD_CYCLES - 1);
                clr_pend_d = 1'b0;
                if (latch_q) begin
                    ovr_d = 1'b1;
                end
            end else begin
                if (latch_q && (irq_clr_i[i] || clr_pend_q) && (cnt_q == '0)) begin
                    latch_d    = 1'b0;
                    ovr_d      = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (latch_q && irq_clr_i[i] && (cnt_q != '0)) begin
                    clr_pend_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            out_d = (EDGE ? latch_d : s) & irq_en_i[i];
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                sync_q     <= '0;
                prev_q     <= 1'b0;
                latch_q    <= 1'b0;
                cnt_q      <= '0;
                clr_pend_q <= 1'b0;
                ovr_q      <= 1'b0;
                out_q      <= 1'b0;
            end else begin
                sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_raw_i[i]};
                prev_q     <= s;
                latch_q    <= latch_d;
                cnt_q      <= cnt_d;
                clr_pend_q <= clr_pend_d;
                ovr_q      <= ovr_d;
                out_q      <= out_d;
            end
        end

        assign irqs_out[i]      = out_q;
        assign irq_overrun_o[i] = ovr_q;
    end

endmodule

// File: tb/tb_ariane_irq_conditioner.sv
// Directed bench: source 0 in level mode, sources 1 and 2 in edge mode; expected output
// vectors are queued with their target edge and checked on the following falling clock edge.
module tb_ariane_irq_conditioner;

    logic       aclk = 1'b0;
    logic       areset;
    logic [2:0] irq_raw_i;
    logic [2:0] irq_en_i;
    logic [2:0] irq_clr_i;
    logic [2:0] irqs_out;
    logic [2:0] irq_overrun_o;

    int ed    = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at_edge;
        string      tag;
        logic [2:0] out;
        logic [2:0] ovr;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    ariane_irq_conditioner #(
        .NUM_IRQ    (3),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .EDGE_MASK  (3'b110)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .irq_raw_i    (irq_raw_i),
        .irq_en_i     (irq_en_i),
        .irq_clr_i    (irq_clr_i),
        .irqs_out     (irqs_out),
        .irq_overrun_o(irq_overrun_o)
    );

    always #5 aclk = ~aclk;

    // ed == k between posedge k and posedge k+1
    always @(posedge aclk) ed <= ed + 1;

    always @(negedge aclk) begin
        while (sb.size() > 0 && sb[0].at_edge <= ed) begin
            e = sb.pop_front();
            if (e.at_edge != ed) begin
                total++;
                bad++;
                $error("FAIL %s: check for edge %0d reached at edge %0d", e.tag, e.at_edge, ed);
            end else begin
                total++;
                assert (irqs_out === e.out) else begin
                    bad++;
                    $error("FAIL %s.out @%0d: got %b want %b", e.tag, ed, irqs_out, e.out);
                end
                total++;
                assert (irq_overrun_o === e.ovr) else begin
                    bad++;
                    $error("FAIL %s.ovr @%0d: got %b want %b", e.tag, ed, irq_overrun_o, e.ovr);
                end
            end
        end
    end

    task automatic expect_at(input int k, input string tag, input logic [2:0] o, input logic [2:0] v);
        exp_t x;
        x.at_edge = k;
        x.tag     = tag;
        x.out     = o;
        x.ovr     = v;
        sb.push_back(x);
    endtask

    // Return at the falling edge before edge k, so values set now are sampled at edge k.
    task automatic wait_edge(input int k);
        while (ed < k - 1) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: stuck at edge %0d", ed);
        $fatal(1, "timeout");
    end

    initial begin
        areset    = 1'b1;
        irq_raw_i = 3'b000;
        irq_en_i  = 3'b111;
        irq_clr_i = 3'b000;
        expect_at(2, "reset", 3'b000, 3'b000);
        wait_edge(3);
        areset = 1'b0;

        // Level source 0: high sampled 10..29, clear ignored
        wait_edge(10);
        irq_raw_i[0] = 1'b1;
        expect_at(11, "lvl_lat", 3'b000, 3'b000);
        expect_at(12, "lvl_rise", 3'b001, 3'b000);
        wait_edge(20);
        irq_clr_i[0] = 1'b1;
        expect_at(21, "lvl_clr", 3'b001, 3'b000);
        wait_edge(21);
        irq_clr_i[0] = 1'b0;
        wait_edge(30);
        irq_raw_i[0] = 1'b0;
        expect_at(31, "lvl_hold", 3'b001, 3'b000);
        expect_at(32, "lvl_fall", 3'b000, 3'b000);

        // Edge source 1: single-cycle pulse, early clear deferred to end of hold
        wait_edge(40);
        irq_raw_i[1] = 1'b1;
        expect_at(41, "edg_lat", 3'b000, 3'b000);
        expect_at(42, "edg_rise", 3'b010, 3'b000);
        wait_edge(41);
        irq_raw_i[1] = 1'b0;
        wait_edge(44);
        irq_clr_i[1] = 1'b1;
        expect_at(44, "edg_defer", 3'b010, 3'b000);
        wait_edge(45);
        irq_clr_i[1] = 1'b0;
        expect_at(57, "edg_hold", 3'b010, 3'b000);
        expect_at(58, "edg_clr", 3'b000, 3'b000);

        // Edge source 2: second pulse while latched -> overrun; clear after hold drops both
        wait_edge(70);
        irq_raw_i[2] = 1'b1;
        expect_at(71, "ovr_lat", 3'b000, 3'b000);
        expect_at(72, "ovr_rise", 3'b100, 3'b000);
        wait_edge(71);
        irq_raw_i[2] = 1'b0;
        wait_edge(80);
        irq_raw_i[2] = 1'b1;
        expect_at(81, "ovr_pre", 3'b100, 3'b000);
        expect_at(82, "ovr_set", 3'b100, 3'b100);
        wait_edge(81);
        irq_raw_i[2] = 1'b0;
        expect_at(109, "ovr_keep", 3'b100, 3'b100);
        wait_edge(110);
        irq_clr_i[2] = 1'b1;
        expect_at(110, "ovr_clr", 3'b000, 3'b000);
        wait_edge(111);
        irq_clr_i[2] = 1'b0;

        // Rise and clear on the same edge: clear discarded, not deferred
        wait_edge(120);
        irq_raw_i[1] = 1'b1;
        wait_edge(121);
        irq_raw_i[1] = 1'b0;
        wait_edge(122);
        irq_clr_i[1] = 1'b1;
        expect_at(122, "sim_rise", 3'b010, 3'b000);
        wait_edge(123);
        irq_clr_i[1] = 1'b0;
        expect_at(138, "sim_nodefer", 3'b010, 3'b000);
        wait_edge(140);
        irq_clr_i[1] = 1'b1;
        expect_at(140, "sim_clr", 3'b000, 3'b000);
        wait_edge(141);
        irq_clr_i[1] = 1'b0;

        // Masked latch on source 1 shows once enabled
        wait_edge(150);
        irq_en_i     = 3'b101;
        irq_raw_i[1] = 1'b1;
        expect_at(152, "en_mask", 3'b000, 3'b000);
        wait_edge(151);
        irq_raw_i[1] = 1'b0;
        expect_at(159, "en_still", 3'b000, 3'b000);
        wait_edge(160);
        irq_en_i = 3'b111;
        expect_at(160, "en_show", 3'b010, 3'b000);

        // Load all sources, then a one-cycle reset; held inputs come back after resync
        wait_edge(170);
        irq_raw_i = 3'b111;
        wait_edge(171);
        irq_raw_i = 3'b001;
        wait_edge(175);
        irq_raw_i = 3'b101;
        expect_at(178, "pre_rst", 3'b111, 3'b110);
        wait_edge(180);
        areset = 1'b1;
        expect_at(180, "mid_rst", 3'b000, 3'b000);
        wait_edge(181);
        areset = 1'b0;
        expect_at(182, "resync", 3'b000, 3'b000);
        expect_at(183, "relatch", 3'b101, 3'b000);

        wait_edge(190);
        @(negedge aclk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: %0d checks pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
